low_pass_v3: RTL and testbench

Parametrised successor to the two-stage exponential low-pass chain. It provides a configurable cascade of first-order exponential (IIR) stages, each with its own alpha, followed by an optional power-of-two boxcar averager with optional decimation. A sample strobe and a synchronous clear are included, so the block can run at sub-clock sample rates and be re-armed without a full reset. It sits in the Red Pitaya feedback/readout datapath between the ADC sample stream and downstream processing.

---
 rtl/lp_pkg.sv | 29 ++
 rtl/lp_exp_stage.sv | 57 +++++
 rtl/low_pass_v3.sv | 170 +++++++++++++++++
 tb/tb_low_pass_v3.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lp_pkg.sv
// Shared definitions for the low_pass_v3 filter chain.
package lp_pkg;

  // Bit positions within mode_i
  localparam int unsigned MODE_EXP = 0;
  localparam int unsigned MODE_BOX = 1;

  // Widest alpha bus and widest single alpha the slice helper handles
  localparam int unsigned ALPHA_BUS_MAX = 256;
  localparam int unsigned ALPHA_MAX     = 64;

  // Cascade depth must stay within 1..4
  function automatic bit stages_legal(input int unsigned stages);
    return (stages >= 1) && (stages <= 4);
  endfunction

  // Boxcar length exponent must stay within 1..8
  function automatic bit sum_log2_legal(input int unsigned sum_log2);
    return (sum_log2 >= 1) && (sum_log2 <= 8);
  endfunction

  // Alpha for stage k; the caller narrows the result to its own alpha width
  function automatic logic [ALPHA_MAX-1:0] alpha_slice(input logic [ALPHA_BUS_MAX-1:0] bus,
                                                       input int unsigned           k,
                                                       input int unsigned           aw);
    return ALPHA_MAX'(bus >> (k * aw));
  endfunction

endpackage

// File: rtl/lp_exp_stage.sv
// One first-order exponential smoothing stage with its own valid in/out.
module lp_exp_stage #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned ALPHA_WIDTH = 32,
  parameter int unsigned FRAC        = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    valid_i,
  input  logic signed [WIDTH-1:0] data_i,
  input  logic [ALPHA_WIDTH-1:0]  alpha_i,
  output logic                    valid_o,
  output logic signed [WIDTH-1:0] data_o
);

  localparam int unsigned SW = WIDTH + FRAC;
  localparam int unsigned DW = SW + 1;
  localparam int unsigned PW = DW + ALPHA_WIDTH + 1;

  logic signed [SW-1:0] s_q, s_d;
  logic                 valid_q, valid_d;
  logic signed [SW-1:0] x_ext;
  logic signed [DW-1:0] diff;
  logic signed [PW-1:0] prod;

  // Move the state a fraction alpha of the way toward the new sample
  always_comb begin
    x_ext   = $signed({data_i, {FRAC{1'b0}}});
    diff    = DW'(x_ext) - DW'(s_q);
    prod    = PW'(diff) * PW'($signed({1'b0, alpha_i}));
    s_d     = s_q;
    valid_d = valid_i;
    if (clear_i) begin
      s_d     = '0;
      valid_d = 1'b0;
    end else if (valid_i) begin
      // Sum is bounded by the old state and the target, so the wrap is exact
      s_d = s_q + SW'(prod >>> ALPHA_WIDTH);
    end
  end

  // State and valid registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = WIDTH'(s_q >>> FRAC);

endmodule

// File: rtl/low_pass_v3.sv
// Exponential cascade followed by an optional boxcar averager with decimation.
module low_pass_v3
  import lp_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned ALPHA_WIDTH = 32,
  parameter int unsigned STAGES      = 2,
  parameter int unsigned FRAC        = 16,
  parameter int unsigned SUM_LOG2    = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic signed [WIDTH-1:0]         data_i,
  input  logic                            valid_i,
  input  logic [STAGES*ALPHA_WIDTH-1:0]   alpha_i,
  input  logic [1:0]                      mode_i,
  input  logic                            decim_i,
  input  logic                            clear_i,
  output logic signed [WIDTH-1:0]         data_o,
  output logic                            valid_o
);

  localparam int unsigned BOX_N = 1 << SUM_LOG2;
  localparam int unsigned SUMW  = WIDTH + SUM_LOG2;

  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("low_pass_v3: STAGES out of range 1..4");
  end
  if (!sum_log2_legal(SUM_LOG2)) begin : g_bad_sum_log2
    $error("low_pass_v3: SUM_LOG2 out of range 1..8");
  end

  // Input register and raw-data delay line aligned with the cascade
  logic                    in_v_q, in_v_d;
  logic signed [WIDTH-1:0] in_x_q, in_x_d;
  logic signed [WIDTH-1:0] raw_q [STAGES];
  logic signed [WIDTH-1:0] raw_d [STAGES];

  // Cascade taps: index 0 is the input register, index STAGES the last stage
  logic                    st_v [STAGES+1];
  logic signed [WIDTH-1:0] st_x [STAGES+1];

  // Boxcar state
  logic signed [WIDTH-1:0] buf_q [BOX_N];
  logic signed [WIDTH-1:0] buf_d [BOX_N];
  logic [SUM_LOG2-1:0]     ptr_q, ptr_d;
  logic signed [SUMW-1:0]  sum_q, sum_d;
  logic signed [WIDTH-1:0] byp_q, byp_d;
  logic                    box_v_q, box_v_d;
  logic signed [WIDTH-1:0] box_in;

  // Output stage
  logic [SUM_LOG2-1:0]     dcnt_q, dcnt_d;
  logic signed [WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;

  // Capture accepted samples and shift the bypass delay line
  always_comb begin
    in_v_d = valid_i;
    in_x_d = valid_i ? data_i : in_x_q;
    raw_d[0] = in_x_q;
    for (int j = 1; j < int'(STAGES); j++) raw_d[j] = raw_q[j-1];
    if (clear_i) begin
      in_v_d = 1'b0;
      in_x_d = '0;
      for (int j = 0; j < int'(STAGES); j++) raw_d[j] = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      in_v_q <= 1'b0;
      in_x_q <= '0;
      for (int j = 0; j < int'(STAGES); j++) raw_q[j] <= '0;
    end else begin
      in_v_q <= in_v_d;
      in_x_q <= in_x_d;
      for (int j = 0; j < int'(STAGES); j++) raw_q[j] <= raw_d[j];
    end
  end

  assign st_v[0] = in_v_q;
  assign st_x[0] = in_x_q;

  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    lp_exp_stage #(
      .WIDTH       (WIDTH),
      .ALPHA_WIDTH (ALPHA_WIDTH),
      .FRAC        (FRAC)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .valid_i (st_v[k]),
      .data_i  (st_x[k]),
      .alpha_i (ALPHA_WIDTH'(alpha_slice(ALPHA_BUS_MAX'(alpha_i), k, ALPHA_WIDTH))),
      .valid_o (st_v[k+1]),
      .data_o  (st_x[k+1])
    );
  end

  // Boxcar running sum over the last 2^SUM_LOG2 samples
  always_comb begin
    box_in  = mode_i[MODE_EXP] ? st_x[STAGES] : raw_q[STAGES-1];
    buf_d   = buf_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    byp_d   = byp_q;
    box_v_d = st_v[STAGES];
    if (clear_i) begin
      for (int i = 0; i < int'(BOX_N); i++) buf_d[i] = '0;
      ptr_d   = '0;
      sum_d   = '0;
      byp_d   = '0;
      box_v_d = 1'b0;
    end else if (st_v[STAGES]) begin
      sum_d        = sum_q + SUMW'(box_in) - SUMW'(buf_q[ptr_q]);
      buf_d[ptr_q] = box_in;
      ptr_d        = ptr_q + SUM_LOG2'(1);
      byp_d        = box_in;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(BOX_N); i++) buf_q[i] <= '0;
      ptr_q   <= '0;
      sum_q   <= '0;
      byp_q   <= '0;
      box_v_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      byp_q   <= byp_d;
      box_v_q <= box_v_d;
    end
  end

  // Output mux, decimation counter and strobe gating
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    dcnt_d  = dcnt_q;
    if (clear_i) begin
      data_d = '0;
      dcnt_d = '0;
    end else if (box_v_q) begin
      data_d  = mode_i[MODE_BOX] ? WIDTH'(sum_q >>> SUM_LOG2) : byp_q;
      valid_d = !decim_i || (&dcnt_q);
      dcnt_d  = dcnt_q + SUM_LOG2'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_low_pass_v3.sv
// Randomised bench for low_pass_v3 against a sample-level arithmetic model.
module tb_low_pass_v3;

  localparam int unsigned W   = 16;
  localparam int unsigned AW  = 32;
  localparam int unsigned ST  = 2;
  localparam int unsigned FR  = 16;
  localparam int unsigned SL  = 2;
  localparam int          N   = 4;
  localparam int          LAT = 4;

  logic                   clk = 1'b0;
  logic                   rst_i = 1'b0;
  logic signed [W-1:0]    data_i = '0;
  logic                   valid_i = 1'b0;
  logic [ST*AW-1:0]       alpha_i = '0;
  logic [1:0]             mode_i = 2'b00;
  logic                   decim_i = 1'b0;
  logic                   clear_i = 1'b0;
  logic signed [W-1:0]    data_o;
  logic                   valid_o;

  always #5 clk = ~clk;

  low_pass_v3 #(
    .WIDTH (W), .ALPHA_WIDTH (AW), .STAGES (ST), .FRAC (FR), .SUM_LOG2 (SL)
  ) dut (
    .clk_i (clk), .rst_i (rst_i), .data_i (data_i), .valid_i (valid_i),
    .alpha_i (alpha_i), .mode_i (mode_i), .decim_i (decim_i), .clear_i (clear_i),
    .data_o (data_o), .valid_o (valid_o)
  );

  int checks = 0;
  int failures = 0;
  int edge_n = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Model state: exponential states in Q(FR), boxcar contents, sum, pointer, decim count
  typedef struct { int due; int data; bit vout; } exp_t;
  logic signed [31:0] ms [ST];
  int   mbuf [N];
  int   mptr, msum, mcnt;
  exp_t expq [$];
  int   exp_data = 0;
  int   outs [$];
  int   pulses = 0;
  int   first_acc = -1;
  bit   lat_done = 1'b0;

  function automatic logic signed [127:0] floor_div(input logic signed [127:0] n,
                                                     input logic signed [127:0] d);
    logic signed [127:0] q;
    q = n / d;
    if ((q * d != n) && (n < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < int'(ST); k++) ms[k] = '0;
    for (int i = 0; i < N; i++) mbuf[i] = 0;
    mptr = 0; msum = 0; mcnt = 0;
    expq.delete();
    exp_data = 0;
  endtask

  // One accepted sample through cascade, boxcar, mux and decimation
  task automatic model_sample(input int d, input int due);
    logic signed [127:0] x, s_w, a_w, diff;
    int   casc, xin, avg;
    exp_t e;
    x = d;
    for (int k = 0; k < int'(ST); k++) begin
      s_w  = ms[k];
      a_w  = {96'b0, alpha_i[k*AW +: AW]};
      diff = x * 65536 - s_w;
      s_w  = s_w + floor_div(diff * a_w, 128'sd4294967296);
      ms[k] = 32'(s_w);
      x    = floor_div(s_w, 128'sd65536);
    end
    casc = 32'(x);
    xin  = mode_i[0] ? casc : d;
    msum = msum + xin - mbuf[mptr];
    mbuf[mptr] = xin;
    mptr = (mptr + 1) % N;
    avg  = 32'(floor_div(msum, N));
    e.due  = due;
    e.data = mode_i[1] ? avg : xin;
    e.vout = !decim_i || (mcnt == N - 1);
    mcnt = (mcnt + 1) % N;
    expq.push_back(e);
  endtask

  task automatic check_outputs();
    bit ev;
    ev = 1'b0;
    if (expq.size() > 0 && expq[0].due == edge_n) begin
      exp_data = expq[0].data;
      ev = expq[0].vout;
      void'(expq.pop_front());
    end
    check_eq("valid_o", 32'(valid_o), 32'(ev));
    check_eq("data_o", data_o, exp_data);
    if (valid_o === 1'b1) begin
      outs.push_back(int'(data_o));
      pulses++;
      if (!lat_done && first_acc >= 0) begin
        check_eq("first_latency", edge_n - first_acc, LAT);
        lat_done = 1'b1;
      end
    end
  endtask

  // Check the outputs of the last edge, then drive inputs for the next edge
  task automatic cycle(input bit v, input int d, input bit clr);
    @(negedge clk);
    check_outputs();
    valid_i = v;
    data_i  = W'(d);
    clear_i = clr;
    if (rst_i) begin
      if (clr) model_clear();
      else if (v) begin
        model_sample(d, edge_n + 1 + LAT);
        if (first_acc < 0) first_acc = edge_n + 1;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 2; i++) cycle(1'b0, 0, 1'b0);
  endtask

  task automatic restart(input logic [1:0] m, input bit dec);
    drain();
    mode_i  = m;
    decim_i = dec;
    cycle(1'b0, 0, 1'b1);
    drain();
    outs.delete();
    pulses = 0;
  endtask

  // Compare collected output strobes against a directed table
  task automatic check_outs(input string tag, input int n, input int m, input int tab [8]);
    check_eq({tag, "_count"}, outs.size(), n);
    for (int i = 0; i < m; i++)
      check_eq(tag, (i < outs.size()) ? outs[i] : 32'sh7fff_ffff, tab[i]);
  endtask

  function automatic int rnd_sample();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  initial begin
    bit mono;
    model_clear();

    // Reset held with traffic on the input
    for (int i = 0; i < 5; i++) cycle(1'b1, 1000, 1'b0);
    rst_i = 1'b1;
    valid_i = 1'b0;

    // Bypass
    mode_i = 2'b00;
    cycle(1'b1, 1234, 1'b0);
    cycle(1'b1, -5, 1'b0);
    cycle(1'b1, 32767, 1'b0);
    drain();
    check_outs("bypass", 3, 3, '{1234, -5, 32767, 0, 0, 0, 0, 0});

    // Cascade step response with alpha = 1/2 on both stages
    alpha_i = {32'h8000_0000, 32'h8000_0000};
    restart(2'b01, 1'b0);
    cycle(1'b1, 0, 1'b0);
    for (int i = 0; i < 15; i++) cycle(1'b1, 1000, 1'b0);
    drain();
    check_outs("cascade", 16, 4, '{0, 250, 500, 687, 0, 0, 0, 0});
    mono = 1'b1;
    for (int i = 1; i < outs.size(); i++)
      if (outs[i] < outs[i-1] || outs[i] > 1000) mono = 1'b0;
    check_eq("cascade_monotonic", 32'(mono), 1);

    // Boxcar impulses, second one crosses the pointer wrap
    restart(2'b10, 1'b0);
    cycle(1'b1, 400, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 0, 1'b0);
    cycle(1'b1, -400, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 0, 1'b0);
    drain();
    check_outs("boxcar", 11, 8, '{100, 100, 100, 100, 0, 0, -100, -100});

    // Decimation: 12 samples give exactly 3 strobes, then gapped traffic
    restart(2'b10, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b1, rnd_sample(), 1'b0);
    drain();
    check_eq("decim_pulses", pulses, 3);
    for (int i = 0; i < 40; i++) cycle(1'($urandom), rnd_sample(), 1'b0);
    drain();

    // Clear coinciding with a valid sample in mode 11, then a fresh impulse
    alpha_i = {32'h2000_0000, 32'h4000_0000};
    restart(2'b11, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, rnd_sample(), 1'b0);
    cycle(1'b1, 777, 1'b1);
    pulses = 0;
    drain();
    check_eq("clear_no_strobe", pulses, 0);
    outs.delete();
    cycle(1'b1, 400, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 0, 1'b0);
    drain();
    check_eq("post_clear_count", outs.size(), 8);

    // Random segments: configuration changes only while the pipe is empty
    for (int seg = 0; seg < 30; seg++) begin
      drain();
      mode_i  = 2'($urandom);
      decim_i = 1'($urandom);
      alpha_i = {32'($urandom), 32'($urandom)};
      for (int i = 0; i < 100; i++)
        cycle(($urandom_range(3, 0) != 0), rnd_sample(), ($urandom_range(49, 0) == 0));
    end
    drain();
    check_eq("queue_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
